// File: rtl/time_fmt_m_if.sv
// time_fmt_m handshake + result bus.
// master: start/timestamp out; slave: busy/done/err/digits/pm out.
interface time_fmt_m_if #(
  parameter int TS_W = 17
);
  logic            start;
  logic [TS_W-1:0] timestamp;
  logic            busy;
  logic            done;
  logic            err;
  logic            hour_tens;
  logic [3:0]      hour_ones;
  logic [2:0]      min_tens;
  logic [3:0]      min_ones;
  logic [2:0]      sec_tens;
  logic [3:0]      sec_ones;
  logic            pm;

  modport master (
    output start, timestamp,
    input  busy, done, err, pm,
    input  hour_tens, hour_ones,
    input  min_tens, min_ones,
    input  sec_tens, sec_ones
  );

  modport slave (
    input  start, timestamp,
    output busy, done, err, pm,
    output hour_tens, hour_ones,
    output min_tens, min_ones,
    output sec_tens, sec_ones
  );
endinterface

// File: rtl/time_fmt_m.sv
// Seconds-of-day -> 12h BCD formatter by repeated subtraction.
// Ports: clock, reset (sync, active high), bus (time_fmt_m_if.slave).
module time_fmt_m #(
  parameter int MAX_TS = 86399,
  parameter int TS_W   = 17
) (
  input logic        clock,
  input logic        reset,
  time_fmt_m_if.slave bus
);

  localparam logic [TS_W-1:0] MAX_V = TS_W'(MAX_TS);
  localparam logic [TS_W-1:0] HR_V  = TS_W'(3600);
  localparam logic [TS_W-1:0] MN_V  = TS_W'(60);

  typedef enum logic [1:0] {
    IDLE,
    HOURS,
    MINUTES,
    CONVERT
  } state_t;

  state_t state, state_nxt;

  logic [TS_W-1:0] rem;
  logic [4:0]      h24;
  logic [5:0]      mins;

  logic accept, reject;

  logic       busy_q, done_q, err_q, pm_q;
  logic       ht_q;
  logic [3:0] ho_q;
  logic [2:0] mt_q;
  logic [3:0] mo_q;
  logic [2:0] st_q;
  logic [3:0] so_q;

  logic       pm_nxt, ht_nxt;
  logic [4:0] h12;
  logic [3:0] ho_nxt;
  logic [2:0] mt_nxt;
  logic [3:0] mo_nxt;
  logic [2:0] st_nxt;
  logic [3:0] so_nxt;

  // Operands are always < 60, so a compare chain
  // replaces a divider.
  function automatic logic [6:0] bcd(
    input logic [5:0] v
  );
    logic [2:0] t;
    if (v >= 6'd50)      t = 3'd5;
    else if (v >= 6'd40) t = 3'd4;
    else if (v >= 6'd30) t = 3'd3;
    else if (v >= 6'd20) t = 3'd2;
    else if (v >= 6'd10) t = 3'd1;
    else                 t = 3'd0;
    return {t, 4'(v - 6'(t) * 6'd10)};
  endfunction

  assign accept = (state == IDLE) && bus.start
                  && (bus.timestamp <= MAX_V);
  assign reject = (state == IDLE) && bus.start
                  && (bus.timestamp > MAX_V);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = HOURS;
      HOURS:   if (rem < HR_V) state_nxt = MINUTES;
      MINUTES: if (rem < MN_V) state_nxt = CONVERT;
      CONVERT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pm_nxt = (h24 >= 5'd12);
    h12    = h24;
    if (h24 == 5'd0)       h12 = 5'd12;
    else if (h24 > 5'd12)  h12 = h24 - 5'd12;
    ht_nxt = (h12 >= 5'd10);
    ho_nxt = 4'(h12 - (ht_nxt ? 5'd10 : 5'd0));
    {mt_nxt, mo_nxt} = bcd(mins);
    {st_nxt, so_nxt} = bcd(rem[5:0]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem  <= '0;
      h24  <= '0;
      mins <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          rem  <= bus.timestamp;
          h24  <= '0;
          mins <= '0;
        end
        HOURS: if (rem >= HR_V) begin
          rem <= rem - HR_V;
          h24 <= h24 + 5'd1;
        end
        MINUTES: if (rem >= MN_V) begin
          rem  <= rem - MN_V;
          mins <= mins + 6'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      pm_q   <= 1'b0;
      ht_q   <= 1'b1;
      ho_q   <= 4'd2;
      mt_q   <= 3'd0;
      mo_q   <= 4'd0;
      st_q   <= 3'd0;
      so_q   <= 4'd0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      done_q <= (state == CONVERT) || reject;
      err_q  <= reject;
      if (state == CONVERT) begin
        pm_q <= pm_nxt;
        ht_q <= ht_nxt;
        ho_q <= ho_nxt;
        mt_q <= mt_nxt;
        mo_q <= mo_nxt;
        st_q <= st_nxt;
        so_q <= so_nxt;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.pm        = pm_q;
  assign bus.hour_tens = ht_q;
  assign bus.hour_ones = ho_q;
  assign bus.min_tens  = mt_q;
  assign bus.min_ones  = mo_q;
  assign bus.sec_tens  = st_q;
  assign bus.sec_ones  = so_q;

endmodule

// File: tb/tb_time_fmt_m.sv
// Testbench for time_fmt_m: directed + random timestamps
// checked against an arithmetic clock-face model.
module tb_time_fmt_m;

  logic clock = 1'b0;
  logic reset = 1'b1;

  time_fmt_m_if #(.TS_W(17)) bus();

  time_fmt_m #(
    .MAX_TS(86399),
    .TS_W  (17)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  int e_ht = 1, e_ho = 2, e_mt = 0;
  int e_mo = 0, e_st = 0, e_so = 0;
  int e_pm = 0;

  task automatic check(
    input string tag,
    input int    got,
    input int    exp
  );
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic model(input int ts, output int lat);
    int h, m, s, h12;
    h    = ts / 3600;
    m    = (ts % 3600) / 60;
    s    = ts % 60;
    h12  = h % 12;
    if (h12 == 0) h12 = 12;
    e_pm = (h >= 12) ? 1 : 0;
    e_ht = h12 / 10;
    e_ho = h12 % 10;
    e_mt = m / 10;
    e_mo = m % 10;
    e_st = s / 10;
    e_so = s % 10;
    lat  = h + m + 3;
  endtask

  task automatic check_out(input string tag);
    check({tag, "_ht"}, int'(bus.hour_tens), e_ht);
    check({tag, "_ho"}, int'(bus.hour_ones), e_ho);
    check({tag, "_mt"}, int'(bus.min_tens),  e_mt);
    check({tag, "_mo"}, int'(bus.min_ones),  e_mo);
    check({tag, "_st"}, int'(bus.sec_tens),  e_st);
    check({tag, "_so"}, int'(bus.sec_ones),  e_so);
    check({tag, "_pm"}, int'(bus.pm),        e_pm);
  endtask

  task automatic launch(input int ts);
    bus.timestamp = 17'(ts);
    bus.start     = 1'b1;
    @(posedge clock);
    #1;
    bus.start     = 1'b0;
  endtask

  // Legal conversion; optional foreign start while busy.
  task automatic run_conv(
    input string tag,
    input int    ts,
    input bit    interfere
  );
    int lat, exp_lat;
    lat = -1;
    launch(ts);
    check({tag, "_busy"}, int'(bus.busy), 1);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      if (interfere && k == 2) begin
        bus.timestamp = 17'd7322;
        bus.start     = 1'b1;
      end else begin
        bus.start     = 1'b0;
      end
      @(posedge clock);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    model(ts, exp_lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, int'(bus.err), 0);
    check({tag, "_idle"}, int'(bus.busy), 0);
    check_out(tag);
  endtask

  task automatic done_clear(input string tag);
    @(posedge clock);
    #1;
    check({tag, "_dclr"}, int'(bus.done), 0);
    check({tag, "_eclr"}, int'(bus.err), 0);
  endtask

  task automatic run_bad(input string tag, input int ts);
    launch(ts);
    check({tag, "_done"}, int'(bus.done), 1);
    check({tag, "_err"},  int'(bus.err),  1);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check_out(tag);
    @(posedge clock);
    #1;
    check({tag, "_dclr"}, int'(bus.done), 0);
    check({tag, "_eclr"}, int'(bus.err),  0);
    check({tag, "_busy2"}, int'(bus.busy), 0);
  endtask

  initial begin
    int ts, dcnt;
    bus.start     = 1'b0;
    bus.timestamp = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err",  int'(bus.err),  0);
    check_out("rst");
    @(negedge clock);
    reset = 1'b0;

    run_conv("ts0", 0, 1'b0);
    done_clear("ts0");
    run_conv("ts45296", 45296, 1'b0);
    done_clear("ts45296");
    run_conv("ts86399", 86399, 1'b0);
    run_conv("ts46800", 46800, 1'b0);
    run_conv("ts3600", 3600, 1'b0);
    done_clear("ts3600");
    run_bad("ts86400", 86400);

    // Foreign start while busy is dropped; then a
    // start issued in the done cycle is accepted.
    run_conv("ign", 45296, 1'b1);
    run_conv("b2b", 3661, 1'b0);
    done_clear("b2b");

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        ts = int'($urandom_range(86400, 131071));
        run_bad($sformatf("rbad%0d", i), ts);
      end else begin
        ts = int'($urandom_range(0, 86399));
        run_conv($sformatf("rnd%0d", i), ts, 1'b0);
        done_clear($sformatf("rnd%0d", i));
      end
    end

    launch(86399);
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    e_ht = 1; e_ho = 2; e_mt = 0;
    e_mo = 0; e_st = 0; e_so = 0;
    e_pm = 0;
    check("mrst_busy", int'(bus.busy), 0);
    check("mrst_done", int'(bus.done), 0);
    check_out("mrst");
    @(negedge clock);
    reset = 1'b0;
    dcnt  = 0;
    repeat (100) begin
      @(posedge clock);
      #1;
      if (bus.done) dcnt++;
    end
    check("mrst_nodone", dcnt, 0);
    check_out("mrst_hold");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
